// File: rtl/ibex_rf_writeback_arbiter.sv
// Merges LSU load responses and EX results into a single registered RF write port.
// EX writes that lose arbitration wait in a small in-order FIFO and are reported to decode as hazards.
module ibex_rf_writeback_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 err_o
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(FifoDepth);

    logic [4:0]           fifo_addr [FifoDepth];
    logic [DataWidth-1:0] fifo_data [FifoDepth];
    logic [FifoDepth-1:0] fifo_vld;
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [CntW-1:0]      cnt;

    logic lsu_bad, ex_bad, lsu_ok, ex_acc, ex_ok;
    logic fifo_empty, push, pop, bypass, err_d;

    always_comb begin
        lsu_bad    = RV32E && lsu_waddr_i[4];
        ex_bad     = RV32E && ex_waddr_i[4];
        lsu_ok     = lsu_valid_i && (lsu_waddr_i != 5'd0) && !lsu_bad;
        ex_acc     = ex_valid_i && ex_ready_o;
        ex_ok      = ex_acc && (ex_waddr_i != 5'd0) && !ex_bad;
        fifo_empty = (cnt == '0);
        // A valid LSU response owns the write slot even when it is dropped.
        pop        = !lsu_valid_i && !fifo_empty;
        push       = ex_ok && (lsu_valid_i || !fifo_empty);
        bypass     = ex_ok && !lsu_valid_i && fifo_empty;
        err_d      = (lsu_valid_i && lsu_bad) || (ex_acc && ex_bad);
    end

    assign ex_ready_o = !rst_i && (cnt != CntFull);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            fifo_vld   <= '0;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= '0;
            err_o      <= 1'b0;
        end else begin
            err_o <= err_d;
            if (push) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PtrOne;
            end
            if (pop) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PtrOne;
            end
            if (push && !pop) begin
                cnt <= cnt + CntOne;
            end else if (pop && !push) begin
                cnt <= cnt - CntOne;
            end

            rf_we_o <= 1'b0;
            if (lsu_valid_i) begin
                if (lsu_ok) begin
                    rf_we_o    <= 1'b1;
                    rf_waddr_o <= lsu_waddr_i;
                    rf_wdata_o <= lsu_wdata_i;
                end
            end else if (!fifo_empty) begin
                rf_we_o    <= 1'b1;
                rf_waddr_o <= fifo_addr[rd_ptr];
                rf_wdata_o <= fifo_data[rd_ptr];
            end else if (bypass) begin
                rf_we_o    <= 1'b1;
                rf_waddr_o <= ex_waddr_i;
                rf_wdata_o <= ex_wdata_i;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by fifo_vld and cnt.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            fifo_addr[wr_ptr] <= ex_waddr_i;
            fifo_data[wr_ptr] <= ex_wdata_i;
        end
    end

    always_comb begin
        hazard_a_o = 1'b0;
        hazard_b_o = 1'b0;
        if (rf_we_o && (rf_waddr_o == raddr_a_i)) hazard_a_o = 1'b1;
        if (rf_we_o && (rf_waddr_o == raddr_b_i)) hazard_b_o = 1'b1;
        for (int i = 0; i < FifoDepth; i++) begin
            if (fifo_vld[i] && (fifo_addr[i] == raddr_a_i)) hazard_a_o = 1'b1;
            if (fifo_vld[i] && (fifo_addr[i] == raddr_b_i)) hazard_b_o = 1'b1;
        end
        if (raddr_a_i == 5'd0) hazard_a_o = 1'b0;
        if (raddr_b_i == 5'd0) hazard_b_o = 1'b0;
    end

endmodule

// File: tb/tb_ibex_rf_writeback_arbiter.sv
// Directed bench for ibex_rf_writeback_arbiter (RV32E=1, FifoDepth=2).
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_ibex_rf_writeback_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_ready_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic [4:0]  raddr_a_i, raddr_b_i;
    logic        hazard_a_o, hazard_b_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ibex_rf_writeback_arbiter #(
        .DataWidth(32),
        .RV32E    (1'b1),
        .FifoDepth(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ex_valid_i (ex_valid_i),
        .ex_waddr_i (ex_waddr_i),
        .ex_wdata_i (ex_wdata_i),
        .ex_ready_o (ex_ready_o),
        .lsu_valid_i(lsu_valid_i),
        .lsu_waddr_i(lsu_waddr_i),
        .lsu_wdata_i(lsu_wdata_i),
        .raddr_a_i  (raddr_a_i),
        .raddr_b_i  (raddr_b_i),
        .hazard_a_o (hazard_a_o),
        .hazard_b_o (hazard_b_o),
        .rf_we_o    (rf_we_o),
        .rf_waddr_o (rf_waddr_o),
        .rf_wdata_o (rf_wdata_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk1({tag, "_we"}, rf_we_o, we);
        chk({tag, "_waddr"}, {27'd0, rf_waddr_o}, {27'd0, a});
        chk({tag, "_wdata"}, rf_wdata_o, d);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ex_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        ex_valid_i = v; ex_waddr_i = a; ex_wdata_i = d;
    endtask

    task automatic lsu_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        lsu_valid_i = v; lsu_waddr_i = a; lsu_wdata_i = d;
    endtask

    initial begin
        rst_i = 1'b1;
        ex_drive(1'b0, 5'd0, 32'd0);
        lsu_drive(1'b0, 5'd0, 32'd0);
        raddr_a_i = 5'd0;
        raddr_b_i = 5'd0;

        // reset state
        tick(); tick();
        chk_rf("rst", 1'b0, 5'd0, 32'd0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_ready", ex_ready_o, 1'b0);
        rst_i = 1'b0;
        #1;
        chk1("rel_ready", ex_ready_o, 1'b1);

        // bypass: x5 = DEADBEEF straight through
        ex_drive(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        raddr_a_i = 5'd5;
        #1;
        chk_rf("byp", 1'b1, 5'd5, 32'hDEADBEEF);
        chk1("byp_haz_rf", hazard_a_o, 1'b1);
        chk1("byp_haz_b0", hazard_b_o, 1'b0);
        tick();
        chk_rf("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);
        chk1("idle_haz", hazard_a_o, 1'b0);

        // collision: LSU x3 wins, EX x7 buffered then written
        lsu_drive(1'b1, 5'd3, 32'h11);
        ex_drive(1'b1, 5'd7, 32'h22);
        tick();
        lsu_drive(1'b0, 5'd0, 32'd0);
        ex_drive(1'b0, 5'd0, 32'd0);
        raddr_a_i = 5'd7;
        #1;
        chk_rf("col1", 1'b1, 5'd3, 32'h11);
        chk1("col_haz_fifo", hazard_a_o, 1'b1);
        tick();
        chk_rf("col2", 1'b1, 5'd7, 32'h22);
        tick();
        chk1("col_idle_we", rf_we_o, 1'b0);
        chk1("col_idle_haz", hazard_a_o, 1'b0);

        // full FIFO: LSU busy 4 cycles, EX stalls after 2 accepts, then in-order drain
        lsu_drive(1'b1, 5'd1, 32'h100);
        ex_drive(1'b1, 5'd8, 32'h80);
        #1 chk1("full_rdy0", ex_ready_o, 1'b1);
        tick();
        chk_rf("full_l1", 1'b1, 5'd1, 32'h100);
        lsu_drive(1'b1, 5'd2, 32'h200);
        ex_drive(1'b1, 5'd9, 32'h90);
        #1 chk1("full_rdy1", ex_ready_o, 1'b1);
        tick();
        chk_rf("full_l2", 1'b1, 5'd2, 32'h200);
        lsu_drive(1'b1, 5'd4, 32'h400);
        ex_drive(1'b1, 5'd10, 32'hA0);
        #1 chk1("full_rdy2", ex_ready_o, 1'b0);
        tick();
        chk_rf("full_l3", 1'b1, 5'd4, 32'h400);
        lsu_drive(1'b1, 5'd6, 32'h600);
        raddr_a_i = 5'd8;
        raddr_b_i = 5'd9;
        #1;
        chk1("full_rdy3", ex_ready_o, 1'b0);
        chk1("full_haz_a", hazard_a_o, 1'b1);
        chk1("full_haz_b", hazard_b_o, 1'b1);
        raddr_b_i = 5'd10;
        #1 chk1("full_haz_notacc", hazard_b_o, 1'b0);
        raddr_b_i = 5'd0;
        #1 chk1("full_haz_x0", hazard_b_o, 1'b0);
        tick();
        chk_rf("full_l4", 1'b1, 5'd6, 32'h600);
        lsu_drive(1'b0, 5'd0, 32'd0);
        tick();
        chk_rf("drain_x8", 1'b1, 5'd8, 32'h80);
        chk1("drain_rdy", ex_ready_o, 1'b1);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        #1;
        chk_rf("drain_x9", 1'b1, 5'd9, 32'h90);
        tick();
        chk_rf("drain_x10", 1'b1, 5'd10, 32'hA0);
        tick();
        chk1("drain_done", rf_we_o, 1'b0);
        chk1("drain_rdy_end", ex_ready_o, 1'b1);

        // x0 drop: accepted, silent
        ex_drive(1'b1, 5'd0, 32'h55);
        #1 chk1("x0_rdy", ex_ready_o, 1'b1);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        chk_rf("x0", 1'b0, 5'd10, 32'hA0);
        chk1("x0_err", err_o, 1'b0);

        // RV32E: LSU x20 dropped with error pulse
        lsu_drive(1'b1, 5'd20, 32'h77);
        tick();
        lsu_drive(1'b0, 5'd0, 32'd0);
        chk1("e_lsu_we", rf_we_o, 1'b0);
        chk1("e_lsu_err", err_o, 1'b1);
        tick();
        chk1("e_lsu_err_off", err_o, 1'b0);

        // RV32E: EX x17 still accepted, dropped with error pulse
        ex_drive(1'b1, 5'd17, 32'h99);
        #1 chk1("e_ex_rdy", ex_ready_o, 1'b1);
        tick();
        ex_drive(1'b0, 5'd0, 32'd0);
        chk_rf("e_ex", 1'b0, 5'd10, 32'hA0);
        chk1("e_ex_err", err_o, 1'b1);
        tick();
        chk1("e_ex_err_off", err_o, 1'b0);

        // reset with two buffered entries: nothing buffered may escape
        lsu_drive(1'b1, 5'd1, 32'h1);
        ex_drive(1'b1, 5'd11, 32'hB1);
        tick();
        lsu_drive(1'b1, 5'd2, 32'h2);
        ex_drive(1'b1, 5'd12, 32'hB2);
        tick();
        lsu_drive(1'b0, 5'd0, 32'd0);
        ex_drive(1'b0, 5'd0, 32'd0);
        rst_i = 1'b1;
        #1 chk1("mid_rdy_rst", ex_ready_o, 1'b0);
        tick();
        rst_i = 1'b0;
        raddr_a_i = 5'd11;
        raddr_b_i = 5'd12;
        #1;
        chk_rf("mid_rst", 1'b0, 5'd0, 32'd0);
        chk1("mid_rdy_rel", ex_ready_o, 1'b1);
        chk1("mid_haz_a", hazard_a_o, 1'b0);
        chk1("mid_haz_b", hazard_b_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("mid_no_we", rf_we_o, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_rf_writeback_arbiter.md
IBEX_RF_WRITEBACK_ARBITER -- requirements
Module: ibex_rf_writeback_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning the width of the write data.
REQ-002 SHALL have parameter RV32E, default 0; when 1, only addresses 0..15 are legal.
REQ-003 SHALL have parameter FifoDepth, default 2, meaning the number of EX-write buffer entries (power of two, >=2).
REQ-004 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_i  in  1  reset: synchronous, active-high.
REQ-006 SHALL have port ex_valid_i  in  1  EX stage offers a write.
REQ-007 SHALL have port ex_waddr_i  in  5  EX destination register.
REQ-008 SHALL have port ex_wdata_i  in  DataWidth  EX result.
REQ-009 SHALL have port ex_ready_o  out  1  EX write accepted this cycle when high with ex_valid_i.
REQ-010 SHALL have port lsu_valid_i  in  1  load-response write, always accepted, no backpressure.
REQ-011 SHALL have port lsu_waddr_i  in  5  load destination register.
REQ-012 SHALL have port lsu_wdata_i  in  DataWidth  load data.
REQ-013 SHALL have port raddr_a_i / raddr_b_i  in  5 each  decode-stage read addresses for hazard check.
REQ-014 SHALL have port hazard_a_o / hazard_b_o  out  1 each  read address matches a pending write.
REQ-015 SHALL have port rf_we_o  out  1  register-file write enable, registered.
REQ-016 SHALL have port rf_waddr_o  out  5  register-file write address, registered.
REQ-017 SHALL have port rf_wdata_o  out  DataWidth  register-file write data, registered.
REQ-018 SHALL have port err_o  out  1  one-cycle pulse on a dropped illegal-address write.

Function
REQ-019 SHALL issue at most one register-file write per cycle via the rf_* output register.
REQ-020 SHALL select per cycle, in this priority: LSU write if lsu_valid_i; else the FIFO head if the FIFO is non-empty; else a direct EX bypass if an EX write is accepted and the FIFO is empty.
REQ-021 SHALL update rf_* one clock after selection (latency 1); if nothing is selected, rf_we_o=0 and rf_waddr_o/rf_wdata_o hold their values.
REQ-022 SHALL drive ex_ready_o = !full, computed from the registered count only; a push is never allowed into a full FIFO, even on a same-cycle pop.
REQ-023 SHALL push an accepted EX write into the FIFO when it is not bypassed, i.e. when lsu_valid_i=1 or the FIFO is non-empty, preserving EX program order.
REQ-024 SHALL allow a simultaneous push and pop; the count is unchanged, and the pointers wrap modulo FifoDepth.
REQ-025 SHALL drop writes to address 0 (EX accepted with ex_ready_o per REQ-022, never pushed, no rf_we_o, no err_o).
REQ-026 SHALL drop, when RV32E=1, any write with waddr[4]=1, and pulse err_o the next cycle; an EX write is still accepted per REQ-022.
REQ-027 SHALL, if an LSU write and a buffered EX entry target the same register, write the LSU value first and the EX value later (EX value final).
REQ-028 SHALL assert hazard_x_o combinationally when raddr_x_i is non-zero and equals the address of any valid FIFO entry, or of the rf_* register while rf_we_o=1.
REQ-029 SHALL not assert hazard_x_o for raddr_x_i=0.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, clear the FIFO (count=0, pointers=0), rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, and err_o=0.
REQ-031 SHALL hold ex_ready_o=0 while rst_i=1 and ignore all inputs during reset; in-flight buffered writes are discarded.
REQ-032 SHALL drive ex_ready_o=1 on the first cycle after reset release.

Verification
REQ-033 SHALL cover the bypass case: EX write x5=0xDEADBEEF with idle LSU and empty FIFO -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF.
REQ-034 SHALL cover a collision: same cycle LSU x3=0x11 and EX x7=0x22 -> cycle+1 writes x3=0x11; cycle+2 writes x7=0x22; hazard_a_o=1 for raddr_a_i=7 during the buffered cycle.
REQ-035 SHALL cover a full FIFO: lsu_valid_i held high for 4 cycles with continuous EX writes -> ex_ready_o=0 after 2 accepts, then EX entries drain in order once LSU stops.
REQ-036 SHALL cover writes to x0 and RV32E: EX write to x0 -> no rf_we_o, no err_o; with RV32E=1, LSU write to x20 -> no rf_we_o, err_o=1 for one cycle.
REQ-037 SHALL cover reset mid-operation: FIFO holding 2 entries, then rst_i=1 for 1 cycle -> rf_we_o=0, no buffered write ever emitted, and ex_ready_o=1 after release.
